tt_um_monishvr_fifo_master: RTL
===============================

# tt_um_monishvr_fifo_master

Self-checking traffic master for the 4-bit TinyTapeout FIFO. It drives the FIFO's write/read strobes and write data, and obeys the FIFO's full/empty flags. It generates an incrementing write pattern, checks read-back data against the same sequence, and reports busy and sticky error status. Its `uo_out` pins connect bit-for-bit to the FIFO's `ui_in`, and the FIFO's `uo_out` connects to this block's `ui_in`, so the two tiles form a closed loop.

## Interface
- `TIMEOUT`, default 15: stall limit in cycles while waiting on full/empty; legal range 1..15.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `ena` input 1: TinyTapeout enable; no functional effect.
- `ui_in` input 8:
  - [0] fifo_full
  - [1] fifo_empty
  - [5:2] fifo_rdata
  - [7:6] ignored
- `uo_out` output 8:
  - [0] busy
  - [1] err (sticky)
  - [2] wr_en
  - [3] rd_en
  - [7:4] wdata
- `uio_in` input 8:
  - [0] start_wr
  - [1] start_rd
  - [3:2] len code: 00=1, 01=2, 10=4, 11=8 words
  - [7:4] ignored
- `uio_out` output 8:
  - [7:4] last_rdata
  - [3:0] = 0
- `uio_oe` output 8: constant 8'hF0, including during reset.

## Operation
Registers:
- state
- 4-bit `wcnt`: next write value
- 4-bit `rcnt`: next expected read value
- 4-bit `remaining`
- 4-bit `tcnt`: timeout counter
- `err`
- `last_rdata`
- previous-sample registers for start_wr and start_rd (edge detect)

Start detection:
- A start is a rising edge: current sample 1, previous sample 0.
- A held-high level never retriggers.
- Starts are accepted only in IDLE; edges arriving while busy are dropped.
- Simultaneous start_wr and start_rd edges: write wins; the read edge is dropped.
- Accepting a start loads `remaining` from the len code.

States:
- **IDLE**: busy=0. Write edge -> WR_CHK. Read edge -> RD_CHK. `tcnt` cleared on entry to any CHK state.
- **WR_CHK**:
  - fifo_full=0 -> WR_STB.
  - Otherwise `tcnt++`. When `tcnt` reaches TIMEOUT: set err, go to IDLE, discard `remaining`, leave `wcnt` unchanged.
- **WR_STB**: wr_en=1 for exactly one cycle with wdata=`wcnt`. Then `wcnt++` (mod 16), `remaining--`, -> WR_GAP.
- **WR_GAP**: one idle cycle so the FIFO flags settle. Then `remaining`==0 -> IDLE, else -> WR_CHK.
- **RD_CHK**: as WR_CHK, but tests fifo_empty.
- **RD_STB**: rd_en=1 for one cycle, -> RD_CAP.
- **RD_CAP**:
  - Capture fifo_rdata into `last_rdata`.
  - If fifo_rdata != `rcnt`, set err.
  - `rcnt++` (mod 16), `remaining--`.
  - Then `remaining`==0 -> IDLE, else -> RD_CHK.

Output behaviour:
- busy = (state != IDLE).
- wdata always shows `wcnt`.
- All outputs are decoded from registers; no combinational path from any input to any output.
- err is cleared only by reset.

Reset (rst_n=0 at a rising edge, including mid-burst):
- Next state is IDLE.
- `wcnt`, `rcnt`, `remaining`, `tcnt`, err, `last_rdata` all = 0.
- Edge-detect registers = 0. A start held high through reset release therefore registers as an edge on the first cycle after release.
- Output values under reset: `uo_out`=8'h00, `uio_out`=8'h00.

## Timing
Write timing:
- Start edge sampled at edge N -> CHK state at cycle N+1.
- First strobe at N+2 if the flag is clear.
- Each word costs 3 cycles minimum (CHK, STB, GAP). A 4-word write burst with no stall is busy for 12 cycles.

Read timing:
- Read data is sampled the cycle after rd_en (FIFO read latency = 1).
- Each word costs 3 cycles (CHK, STB, CAP).

Other rules:
- Stall timeout fires after TIMEOUT consecutive cycles with the flag set.
- Flags are sampled only in CHK states; flag changes during STB/GAP/CAP are ignored.

## Test plan
1. **Reset:** hold rst_n=0 for 2 cycles -> `uo_out`=00, `uio_out`=00, `uio_oe`=F0. Release with start_wr held high -> exactly one burst.
2. **Write burst:** len=10, full=0, pulse start_wr -> 4 wr_en pulses, 3 cycles apart, with wdata 0,1,2,3. Busy high for 12 cycles. wdata then reads 4.
3. **Full stall:** full=1, start_wr -> no wr_en; err=1 after 15 cycles; back to IDLE. Then full=0 and a new start -> first write data = 0.
4. **Clean read:** len=01, model returns 0 then 1 on the cycle after each rd_en -> err=0, `uio_out`[7:4]=1, busy drops.
5. **Mismatch:** first read returns 5 while 0 is expected -> err=1 in the cycle after RD_CAP. err stays 1 through a later clean burst until reset.
6. **Loop-back:** simultaneous start_wr/start_rd edges -> write burst only. Then connect to the real FIFO: write 4 words, read 4 words -> err=0, last_rdata=3.

Source files
------------

// File: rtl/tt_um_monishvr_fifo_master.sv
// Traffic master for the 4-bit TinyTapeout FIFO: writes an incrementing pattern, reads it back,
// checks every word and reports busy plus a sticky error flag.
module tt_um_monishvr_fifo_master #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrChk = 3'd1,
        StWrStb = 3'd2,
        StWrGap = 3'd3,
        StRdChk = 3'd4,
        StRdStb = 3'd5,
        StRdCap = 3'd6
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic [3:0] remaining_q, remaining_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic       err_q, err_d;
    logic [3:0] last_rdata_q, last_rdata_d;
    logic       start_wr_prev_q, start_rd_prev_q;

    logic       fifo_full, fifo_empty;
    logic [3:0] fifo_rdata;
    logic       start_wr, start_rd;
    logic       wr_edge, rd_edge;
    logic [3:0] len_words;
    logic [3:0] tcnt_inc;
    logic       unused;

    assign fifo_full  = ui_in[0];
    assign fifo_empty = ui_in[1];
    assign fifo_rdata = ui_in[5:2];
    assign start_wr   = uio_in[0];
    assign start_rd   = uio_in[1];
    assign wr_edge    = start_wr & ~start_wr_prev_q;
    assign rd_edge    = start_rd & ~start_rd_prev_q;
    assign tcnt_inc   = tcnt_q + 4'd1;
    assign unused     = ^{ena, ui_in[7:6], uio_in[7:4]};

    always_comb begin
        unique case (uio_in[3:2])
            2'b00:   len_words = 4'd1;
            2'b01:   len_words = 4'd2;
            2'b10:   len_words = 4'd4;
            default: len_words = 4'd8;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        remaining_d  = remaining_q;
        tcnt_d       = 4'd0;
        err_d        = err_q;
        last_rdata_d = last_rdata_q;

        unique case (state_q)
            StIdle: begin
                // Write wins over a simultaneous read edge.
                if (wr_edge) begin
                    state_d     = StWrChk;
                    remaining_d = len_words;
                end else if (rd_edge) begin
                    state_d     = StRdChk;
                    remaining_d = len_words;
                end
            end
            StWrChk: begin
                if (!fifo_full) begin
                    state_d = StWrStb;
                end else if (tcnt_inc == TimeoutCnt) begin
                    err_d       = 1'b1;
                    remaining_d = 4'd0;
                    state_d     = StIdle;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            StWrStb: begin
                wcnt_d      = wcnt_q + 4'd1;
                remaining_d = remaining_q - 4'd1;
                state_d     = StWrGap;
            end
            StWrGap: begin
                state_d = (remaining_q == 4'd0) ? StIdle : StWrChk;
            end
            StRdChk: begin
                if (!fifo_empty) begin
                    state_d = StRdStb;
                end else if (tcnt_inc == TimeoutCnt) begin
                    err_d       = 1'b1;
                    remaining_d = 4'd0;
                    state_d     = StIdle;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            StRdStb: begin
                state_d = StRdCap;
            end
            StRdCap: begin
                last_rdata_d = fifo_rdata;
                if (fifo_rdata != rcnt_q) begin
                    err_d = 1'b1;
                end
                rcnt_d      = rcnt_q + 4'd1;
                remaining_d = remaining_q - 4'd1;
                state_d     = (remaining_q == 4'd1) ? StIdle : StRdChk;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            wcnt_q          <= 4'd0;
            rcnt_q          <= 4'd0;
            remaining_q     <= 4'd0;
            tcnt_q          <= 4'd0;
            err_q           <= 1'b0;
            last_rdata_q    <= 4'd0;
            start_wr_prev_q <= 1'b0;
            start_rd_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wcnt_q          <= wcnt_d;
            rcnt_q          <= rcnt_d;
            remaining_q     <= remaining_d;
            tcnt_q          <= tcnt_d;
            err_q           <= err_d;
            last_rdata_q    <= last_rdata_d;
            start_wr_prev_q <= start_wr;
            start_rd_prev_q <= start_rd;
        end
    end

    // Outputs depend on registers only.
    assign uo_out  = {wcnt_q, (state_q == StRdStb), (state_q == StWrStb), err_q,
                      (state_q != StIdle)};
    assign uio_out = {last_rdata_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
